// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter: two-requester TCK-domain arbiter sharing one DMI request/response path.
// Optional response timeout with late-response drain, enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_req_arbiter #(
    parameter logic         FixedPrio     = 1'b0,
    parameter int unsigned  TimeoutCycles = 1024,
    localparam int unsigned ReqW          = 41,
    localparam int unsigned RespW         = 34
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic [1:0][ReqW-1:0]  up_req_i,
    input  logic [1:0]            up_req_valid_i,
    output logic [1:0]            up_req_ready_o,
    output logic [1:0][RespW-1:0] up_resp_o,
    output logic [1:0]            up_resp_valid_o,
    input  logic [1:0]            up_resp_ready_i,
    output logic [ReqW-1:0]       dn_req_o,
    output logic                  dn_req_valid_o,
    input  logic                  dn_req_ready_i,
    input  logic [RespW-1:0]      dn_resp_i,
    input  logic                  dn_resp_valid_i,
    output logic                  dn_resp_ready_o,
    output logic                  owner_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        Idle     = 2'd0,
        Issue    = 2'd1,
        WaitResp = 2'd2
`ifdef DMI_ARB_TIMEOUT_EN
        , Drain  = 2'd3
`endif
    } state_e;

    state_e          r_state;
    logic [ReqW-1:0] r_req;
    logic            r_owner;
    logic            r_last;

    // A timeout below two cycles cannot be represented by the counter
    if (TimeoutCycles < 32'd2) begin : g_timeout_cfg_invalid
    end

    logic w_any;
    logic w_win;
    logic w_idle;
    logic w_wait;
    logic w_timeout;
    logic w_drain;

    // Single requester wins outright; a tie goes to requester 0 or alternates
    assign w_any  = |up_req_valid_i;
    assign w_win  = (&up_req_valid_i) ? (FixedPrio ? 1'b0 : ~r_last) : up_req_valid_i[1];
    assign w_idle = (r_state == Idle);
    assign w_wait = (r_state == WaitResp);

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] r_cnt;

    // A real response in the firing cycle takes precedence over the timeout
    assign w_timeout = w_wait && (r_cnt == CntW'(TimeoutCycles - 1)) && !dn_resp_valid_i;
    assign w_drain   = (r_state == Drain);
`else
    assign w_timeout = 1'b0;
    assign w_drain   = 1'b0;
`endif

    logic             w_resp_valid;
    logic [RespW-1:0] w_resp;

    assign w_resp_valid = w_wait && (dn_resp_valid_i || w_timeout);
    assign w_resp       = w_timeout ? RespW'(2'h2) : dn_resp_i;

    // Response steering: only the owner ever sees data or valid
    always_comb begin
        up_resp_valid_o = 2'b00;
        up_resp_o       = '0;
        if (w_wait) begin
            up_resp_valid_o[r_owner] = w_resp_valid;
            up_resp_o[r_owner]       = w_resp;
        end
    end

    assign up_req_ready_o  = (trst_ni && w_idle && w_any) ? (2'b01 << w_win) : 2'b00;
    assign dn_req_valid_o  = (r_state == Issue);
    assign dn_req_o        = r_req;
    assign dn_resp_ready_o = (w_wait && up_resp_ready_i[r_owner]) || w_drain;
    assign owner_o         = r_owner;
    assign busy_o          = !w_idle;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state <= Idle;
            r_req   <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
`ifdef DMI_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                Idle: begin
                    if (w_any) begin
                        r_req   <= up_req_i[w_win];
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_state <= Issue;
                    end
                end
                Issue: begin
                    if (dn_req_ready_i) begin
                        r_state <= WaitResp;
`ifdef DMI_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                WaitResp: begin
                    if (dn_resp_valid_i && up_resp_ready_i[r_owner]) begin
                        r_state <= Idle;
`ifdef DMI_ARB_TIMEOUT_EN
                    end else if (w_timeout) begin
                        if (up_resp_ready_i[r_owner]) begin
                            r_state <= Drain;
                        end
                    end else if (!dn_resp_valid_i) begin
                        r_cnt <= r_cnt + CntW'(1);
`endif
                    end
                end
`ifdef DMI_ARB_TIMEOUT_EN
                // Swallow the one late response so it never reaches a requester
                Drain: begin
                    if (dn_resp_valid_i) begin
                        r_state <= Idle;
                    end
                end
`endif
                default: r_state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Bench for dmi_req_arbiter: instance 0 round-robin, instance 1 fixed priority.
// Timeout checks run when DMI_ARB_TIMEOUT_EN is defined (TimeoutCycles = 8).
`timescale 1ns/1ps
module tb_dmi_req_arbiter;

    localparam int unsigned ReqW  = 41;
    localparam int unsigned RespW = 34;

    typedef struct {
        int               dut;
        logic [1:0]       valid;
        logic [ReqW-1:0]  req0;
        logic [ReqW-1:0]  req1;
        logic [RespW-1:0] rsp;
        int               dn_wait;
        logic             exp_owner;
    } vec_t;

    logic clk = 1'b0;
    logic trst_n;
    always #5 clk = ~clk;

    logic [1:0][ReqW-1:0]  up_req        [2];
    logic [1:0]            up_req_valid  [2];
    logic [1:0]            up_req_ready  [2];
    logic [1:0][RespW-1:0] up_resp       [2];
    logic [1:0]            up_resp_valid [2];
    logic [1:0]            up_resp_ready [2];
    logic [ReqW-1:0]       dn_req        [2];
    logic                  dn_req_valid  [2];
    logic                  dn_req_ready  [2];
    logic [RespW-1:0]      dn_resp       [2];
    logic                  dn_resp_valid [2];
    logic                  dn_resp_ready [2];
    logic                  owner         [2];
    logic                  busy          [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmi_req_arbiter #(.FixedPrio(1'(g)), .TimeoutCycles(8)) u_dut (
            .tck_i           (clk),
            .trst_ni         (trst_n),
            .up_req_i        (up_req[g]),
            .up_req_valid_i  (up_req_valid[g]),
            .up_req_ready_o  (up_req_ready[g]),
            .up_resp_o       (up_resp[g]),
            .up_resp_valid_o (up_resp_valid[g]),
            .up_resp_ready_i (up_resp_ready[g]),
            .dn_req_o        (dn_req[g]),
            .dn_req_valid_o  (dn_req_valid[g]),
            .dn_req_ready_i  (dn_req_ready[g]),
            .dn_resp_i       (dn_resp[g]),
            .dn_resp_valid_i (dn_resp_valid[g]),
            .dn_resp_ready_o (dn_resp_ready[g]),
            .owner_o         (owner[g]),
            .busy_o          (busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [ReqW:0]  sb_req[$];
    logic [RespW:0] sb_rsp[$];
    vec_t vecs[12];

    function automatic logic [ReqW-1:0] mkreq(input logic [6:0] a, input logic [1:0] op, input logic [31:0] dat);
        return {a, op, dat};
    endfunction

    function automatic logic [RespW-1:0] mkrsp(input logic [31:0] dat, input logic [1:0] r);
        return {dat, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_req(input int d);
        logic [ReqW:0] e;
        if (sb_req.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_req_empty: got dn_req %0h expected none queued", dn_req[d]);
        end else begin
            e = sb_req.pop_front();
            chk("dn_req_payload", dn_req[d], e[ReqW-1:0]);
            chk("dn_req_owner", owner[d], e[ReqW]);
        end
    endtask

    task automatic pop_rsp(input int d);
        logic [RespW:0] e;
        if (sb_rsp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_rsp_empty: got up_resp_valid %0h expected none queued", up_resp_valid[d]);
        end else begin
            e = sb_rsp.pop_front();
            chk("up_resp_valid", up_resp_valid[d], 2'b01 << e[RespW]);
            chk("up_resp_owner_data", up_resp[d][e[RespW]], e[RespW-1:0]);
            chk("up_resp_other_zero", up_resp[d][!e[RespW]], 0);
        end
    endtask

    // One full transaction: grant, issue (with downstream stall), response
    task automatic run_vec(input vec_t v);
        int d;
        logic o;
        d = v.dut;
        o = v.exp_owner;
        up_req[d][0]     = v.req0;
        up_req[d][1]     = v.req1;
        up_req_valid[d]  = v.valid;
        up_resp_ready[d] = 2'b11;
        #3;
        chk("grant", up_req_ready[d], 2'b01 << o);
        chk("idle_no_dn_valid", dn_req_valid[d], 0);
        sb_req.push_back({o, o ? v.req1 : v.req0});
        tick();
        up_req_valid[d][o] = 1'b0;
        #3;
        chk("issue_latency", dn_req_valid[d], 1);
        chk("owner", owner[d], o);
        chk("no_grant_while_busy", up_req_ready[d], 0);
        for (int i = 0; i < v.dn_wait; i++) begin
            tick();
            #3;
            chk("dn_valid_hold", dn_req_valid[d], 1);
            chk("dn_req_hold", dn_req[d], o ? v.req1 : v.req0);
        end
        dn_req_ready[d] = 1'b1;
        pop_req(d);
        tick();
        dn_req_ready[d]  = 1'b0;
        dn_resp[d]       = v.rsp;
        dn_resp_valid[d] = 1'b1;
        sb_rsp.push_back({o, v.rsp});
        #3;
        pop_rsp(d);
        chk("dn_resp_ready", dn_resp_ready[d], 1);
        chk("no_same_cycle_grant", up_req_ready[d], 0);
        tick();
        dn_resp_valid[d] = 1'b0;
        dn_resp[d]       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 2'b10, '0, mkreq(7'h11, 2'd1, 32'h0), mkrsp(32'h1111_0011, 2'd0), 0, 1'b1};
        vecs[1] = '{1, 2'b10, '0, mkreq(7'h11, 2'd1, 32'h0), mkrsp(32'h2222_0011, 2'd0), 0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            vecs[2+i] = '{0, 2'b11, mkreq(7'(8'h20 + i), 2'd2, 32'hA000_0000 + i),
                          mkreq(7'(8'h30 + i), 2'd1, 32'hB000_0000 + i),
                          mkrsp(32'hC000_0000 + i, 2'(i)), i % 2, 1'(i % 2)};
            vecs[7+i] = '{1, 2'b11, mkreq(7'(8'h40 + i), 2'd1, 32'h0),
                          mkreq(7'(8'h50 + i), 2'd2, 32'hD000_0000 + i),
                          mkrsp(32'hE000_0000 + i, 2'd0), 1, 1'b0};
        end
        vecs[6]  = '{0, 2'b01, mkreq(7'h04, 2'd1, 32'h0), '0, mkrsp(32'hDEAD_BEEF, 2'd0), 3, 1'b0};
        vecs[11] = '{1, 2'b10, '0, mkreq(7'h5F, 2'd2, 32'h0F0F_0F0F), mkrsp(32'h1234_5678, 2'd0), 2, 1'b1};

        trst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            up_req[d]        = '0;
            up_req[d][1]     = mkreq(7'h11, 2'd1, 32'h0);
            up_req_valid[d]  = 2'b10;
            up_resp_ready[d] = 2'b11;
            dn_req_ready[d]  = 1'b1;
            dn_resp[d]       = mkrsp(32'hFFFF_FFFF, 2'd3);
            dn_resp_valid[d] = 1'b1;
        end
        repeat (3) tick();
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_up_req_ready", up_req_ready[d], 0);
            chk("rst_up_resp_valid", up_resp_valid[d], 0);
            chk("rst_dn_req_valid", dn_req_valid[d], 0);
            chk("rst_dn_resp_ready", dn_resp_ready[d], 0);
            chk("rst_dn_req", dn_req[d], 0);
            chk("rst_owner", owner[d], 0);
            up_req_valid[d]  = 2'b00;
            dn_req_ready[d]  = 1'b0;
            dn_resp_valid[d] = 1'b0;
            dn_resp[d]       = '0;
        end
        tick();
        trst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response backpressure on the owner stalls everything
        up_req[0][0]     = mkreq(7'h05, 2'd1, 32'h0);
        up_req_valid[0]  = 2'b01;
        up_resp_ready[0] = 2'b11;
        #3;
        chk("bp_grant", up_req_ready[0], 2'b01);
        sb_req.push_back({1'b0, mkreq(7'h05, 2'd1, 32'h0)});
        tick();
        up_req_valid[0] = 2'b10;
        up_req[0][1]    = mkreq(7'h06, 2'd2, 32'h1234_5678);
        dn_req_ready[0] = 1'b1;
        #3;
        pop_req(0);
        tick();
        dn_req_ready[0]  = 1'b0;
        dn_resp_valid[0] = 1'b1;
        dn_resp[0]       = mkrsp(32'hCAFE_F00D, 2'd0);
        up_resp_ready[0] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("bp_dn_resp_ready", dn_resp_ready[0], 0);
            chk("bp_busy", busy[0], 1);
            chk("bp_no_grant", up_req_ready[0], 0);
            chk("bp_resp_valid", up_resp_valid[0], 2'b01);
            tick();
        end
        up_resp_ready[0] = 2'b11;
        sb_rsp.push_back({1'b0, mkrsp(32'hCAFE_F00D, 2'd0)});
        #3;
        pop_rsp(0);
        chk("bp_release_ready", dn_resp_ready[0], 1);
        tick();
        dn_resp_valid[0] = 1'b0;
        #3;
        chk("bp_next_grant", up_req_ready[0], 2'b10);
        sb_req.push_back({1'b1, mkreq(7'h06, 2'd2, 32'h1234_5678)});
        tick();
        up_req_valid[0] = 2'b00;
        dn_req_ready[0] = 1'b1;
        #3;
        pop_req(0);
        tick();
        dn_req_ready[0] = 1'b0;

        // Reset asserted while waiting for a response drops it entirely
        dn_resp_valid[0] = 1'b1;
        dn_resp[0]       = mkrsp(32'h5555_AAAA, 2'd0);
        #3;
        chk("mid_wait_resp_valid", up_resp_valid[0], 2'b10);
        trst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_resp_valid", up_resp_valid[0], 0);
        chk("mid_rst_dn_resp_ready", dn_resp_ready[0], 0);
        chk("mid_rst_owner", owner[0], 0);
        chk("mid_rst_dn_req", dn_req[0], 0);
        tick();
        trst_n = 1'b1;
        tick();
        dn_resp_valid[0] = 1'b0;
        #3;
        chk("post_rst_no_replay", up_resp_valid[0], 0);
        chk("post_rst_idle", busy[0], 0);
        tick();

        // Withheld response
        up_req[0][0]    = mkreq(7'h07, 2'd1, 32'h0);
        up_req_valid[0] = 2'b01;
        #3;
        chk("to_grant", up_req_ready[0], 2'b01);
        sb_req.push_back({1'b0, mkreq(7'h07, 2'd1, 32'h0)});
        tick();
        up_req_valid[0] = 2'b00;
        dn_req_ready[0] = 1'b1;
        #3;
        pop_req(0);
        tick();
        dn_req_ready[0] = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            #3;
            chk("to_quiet", up_resp_valid[0], 0);
            tick();
        end
        #3;
        chk("to_err_valid", up_resp_valid[0], 2'b01);
        chk("to_err_payload", up_resp[0][0], mkrsp(32'h0, 2'h2));
        chk("to_err_other", up_resp[0][1], 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("drain_busy", busy[0], 1);
            chk("drain_no_valid", up_resp_valid[0], 0);
            chk("drain_ready", dn_resp_ready[0], 1);
            tick();
        end
        dn_resp_valid[0] = 1'b1;
        dn_resp[0]       = mkrsp(32'hBAD0_BAD0, 2'd0);
        #3;
        chk("late_discard", up_resp_valid[0], 0);
        chk("late_busy", busy[0], 1);
        tick();
        dn_resp_valid[0] = 1'b0;
        #3;
        chk("late_idle", busy[0], 0);
`else
        for (int k = 0; k < 12; k++) begin
            #3;
            chk("wait_quiet", up_resp_valid[0], 0);
            chk("wait_busy", busy[0], 1);
            tick();
        end
        dn_resp_valid[0] = 1'b1;
        dn_resp[0]       = mkrsp(32'h600D_600D, 2'd0);
        sb_rsp.push_back({1'b0, mkrsp(32'h600D_600D, 2'd0)});
        #3;
        pop_rsp(0);
        tick();
        dn_resp_valid[0] = 1'b0;
        #3;
        chk("wait_idle", busy[0], 0);
`endif
        chk("sb_req_drained", 64'(sb_req.size()), 0);
        chk("sb_rsp_drained", 64'(sb_rsp.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_req_arbiter.md
Name: dmi_req_arbiter

Overview:
- Two-requester arbiter in the TCK domain. It shares the single DMI request/response path that feeds the JTAG-to-core DMI clock-domain crossing.
- Requester 0 is the JTAG DTM shift/update FSM. Requester 1 is a second TCK-domain DMI master, e.g. a scripted halt/resume sequencer.
- At most one transaction is outstanding at a time. Each response is routed back to the requester that issued the request.

Parameters:
- FixedPrio, 1'b0: 0 = round-robin between the two requesters; 1 = requester 0 always wins.
- TimeoutCycles, 1024: response timeout in TCK cycles. Used only when DMI_ARB_TIMEOUT_EN is defined. Must be ≥ 2.

Ports:
- tck_i  in  1  arbiter clock (JTAG TCK).
- trst_ni  in  1  reset; asynchronous, active-low.
- up_req_i  in  2x41  per-requester dm::dmi_req_t {addr[6:0], op[1:0], data[31:0]}.
- up_req_valid_i  in  2  per-requester request valid.
- up_req_ready_o  out  2  per-requester request accept.
- up_resp_o  out  2x34  per-requester dm::dmi_resp_t {data[31:0], resp[1:0]}.
- up_resp_valid_o  out  2  per-requester response valid.
- up_resp_ready_i  in  2  per-requester response ready.
- dn_req_o  out  41  request toward the CDC.
- dn_req_valid_o  out  1  downstream request valid.
- dn_req_ready_i  in  1  downstream request ready.
- dn_resp_i  in  34  response from the CDC.
- dn_resp_valid_i  in  1  downstream response valid.
- dn_resp_ready_o  out  1  downstream response ready.
- owner_o  out  1  index of the requester holding the current grant (debug/visibility).
- busy_o  out  1  high whenever the FSM is not in Idle.

Behaviour:
- FSM states: Idle, Issue, WaitResp, and Drain (Drain exists only with the macro).
- Registers: req_q (41b), owner_q, last_q (round-robin pointer), FSM state, and the timeout counter.
- Reset values, applied asynchronously on trst_ni low, including mid-transaction: state = Idle; req_q = 0; owner_q = 0; last_q = 1 (so requester 0 wins the first tie); counter = 0.
  - All valid/ready outputs = 0 and dn_req_o = 0.
  - No pending response is replayed after reset.
- Idle:
  - Arbitration is combinational. With one valid requester, that requester wins.
  - With both valid: FixedPrio = 1 grants 0; FixedPrio = 0 grants !last_q.
  - The winner sees up_req_ready_o[w] = 1 in the same cycle. The loser sees 0.
  - On the handshake: req_q <= up_req_i[w]; owner_q <= w; last_q <= w; go to Issue.
  - up_req_ready_o = 0 in every state other than Idle.
- Issue:
  - dn_req_valid_o = 1 and dn_req_o = req_q; both are held stable until dn_req_ready_i.
  - On the handshake, go to WaitResp. The counter clears.
- Latency: the first downstream valid occurs exactly 1 cycle after the upstream accept.
- WaitResp:
  - Every accepted op (read, write or nop) yields exactly one downstream response.
  - up_resp_valid_o[owner_q] = dn_resp_valid_i and up_resp_o[owner_q] = dn_resp_i.
  - dn_resp_ready_o = up_resp_ready_i[owner_q].
  - The non-owner's response valid is always 0 and its up_resp_o = 0.
  - On the handshake, go to Idle. A new grant is possible in the cycle after the response handshake, not the same cycle.
- Back-to-back: under continuous contention with FixedPrio = 0, grants strictly alternate 0,1,0,1.
- The downstream response is combinationally passed through. There are no combinational paths from upstream ready to downstream valid.
- A requester that drops valid before being granted loses nothing; no state is recorded.
- owner_o = owner_q.

Optional Feature:
- Macro: DMI_ARB_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle in WaitResp without dn_resp_valid_i.
  - When it reaches TimeoutCycles-1 with no response, the arbiter presents up_resp_valid_o[owner_q] = 1 with data = 0, resp = 2'h2 (op failed) for the owner.
  - On the owner's ready it goes to Drain.
  - Drain: dn_resp_ready_o = 1. The first late dn_resp_valid_i is consumed and discarded with no upstream valid, then the FSM returns to Idle.
  - If the real response arrives in the same cycle the timeout would fire, the real response wins and no timeout is reported.
- Undefined: no counter and no Drain state; WaitResp waits indefinitely. TimeoutCycles is ignored.

Test Plan:
- Reset: trst_ni low → all valid/ready outputs 0, busy_o = 0, dn_req_o = 0. Release with only requester 1 valid, read addr 0x11 → up_req_ready_o = 2'b10; the next cycle dn_req_o.addr = 0x11, op = read.
- Single read: requester 0 reads addr 0x04, dn_req_ready_i after 3 cycles, response data 0xDEADBEEF resp 0 → up_resp_valid_o = 2'b01 with 0xDEADBEEF; requester 1 sees nothing.
- Contention, round-robin: both requesters valid continuously for 4 transactions, FixedPrio = 0 → owner sequence 0,1,0,1; each payload is delivered unmodified.
- Contention, FixedPrio = 1: same stimulus → requester 0 is granted all 4 times; requester 1 is granted only after requester 0 drops valid.
- Backpressure: hold up_resp_ready_i[owner] = 0 for 5 cycles while the response is valid → dn_resp_ready_o = 0, state stays WaitResp, no new grant. Handshake completes on release.
- Mid-operation reset and timeout (macro on, TimeoutCycles = 8):
  - Assert trst_ni in WaitResp → returns to Idle immediately.
  - Separately, withhold the response → error response resp = 2'h2 after 8 cycles; a late response 3 cycles later is discarded; busy_o falls after the discard.
